aemb2_mtrf: RTL and testbench
=============================

Name: aemb2_mtrf

Overview:
- Parametrised multi-thread general-purpose register file for the AEMB2 pipeline; replaces the fixed two-thread GPR wrapper.
- Holds THR banks of 32 x 32-bit registers. Provides three registered read ports (A, B, D) for the IF/OF boundary and one writeback port with load-lane extraction.
- Includes a round-robin thread sequencer and a post-reset clear sequencer. Optionally forwards writeback data to reads.

Parameters:
- THR, 2, hardware thread count; power of two, 1..8.
- TW, 1, thread-id width = max(1, log2(THR)).

Ports:
- gclk  in  1  system clock, rising edge.
- grst  in  1  reset; asynchronous assert, active-low (asserted when 0).
- dena  in  1  pipeline advance enable.
- ra_if  in  5  port A register address.
- rb_if  in  5  port B register address.
- rd_if  in  5  port D register address.
- wre_mx  in  1  writeback enable.
- thr_mx  in  TW  writeback thread id.
- rd_mx  in  5  writeback register address.
- sel_mx  in  4  byte-lane select for writeback.
- dat_mx  in  32  writeback data, lanes in bus position.
- opa_if  out  32  port A read data.
- opb_if  out  32  port B read data.
- opd_if  out  32  port D read data.
- thr_if  out  TW  thread id of the current read slot.
- clr_busy  out  1  clear sequencer active.

Behaviour:
- Reset (grst=0): opa_if/opb_if/opd_if=0, thr_if=0, clr_busy=1, sequencer enters CLR with index 0.
- Clear FSM, two states, CLR and RUN:
  - CLR: one zero write per gclk to flat index {thread, reg}, counting 0..THR*32-1, independent of dena.
  - CLR -> RUN after the last index is written; clr_busy falls on that same edge.
  - While in CLR: wre_mx is ignored, read outputs hold 0, thr_if holds 0.
  - grst asserted mid-clear restarts CLR at index 0.
- Thread sequencer: in RUN, thr_if increments mod THR on each gclk with dena=1. THR=1 holds 0.
- Reads:
  - On gclk with dena=1 in RUN, each output registers bank[thr_if-next][addr], where thr_if-next is the value thr_if takes on that edge.
  - Latency 1 cycle. dena=0 holds all outputs.
- r0: writes to address 0 are discarded in every bank; reads of address 0 return 0.
- Writeback: on gclk with wre_mx=1 in RUN, write bank[thr_mx][rd_mx]. Write is independent of dena.
- Lane extraction, result zero-extended:
  - 1111: dat_mx.
  - 1100: dat_mx[31:16].
  - 0011: dat_mx[15:0].
  - 1000: [31:24]; 0100: [23:16]; 0010: [15:8]; 0001: [7:0].
  - Any other sel_mx: write suppressed.
- Same-edge write and read of the same {thread, reg} without the bypass feature: the read returns the old value.

Optional Feature:
- Macro AEMB2_RF_BYPASS_EN.
- Defined: a same-edge write whose {thr_mx, rd_mx} matches the read thread and an address (rd_mx≠0) forwards the lane-extracted value to that port. Independent per port.
- Undefined: no forwarding; old value returned; pipeline must stall one slot.

Decomposition:
- Package aemb2_pkg: lane-select constants (SEL_W, SEL_HH, SEL_HL, SEL_B3..SEL_B0), register count 32, data width 32, clear FSM state enum.
- Sub-module aemb2_lane_ext: combinational sel_mx/dat_mx -> {valid, 32-bit value}; shared by the write path and the bypass path.
- Register storage is inferred; no vendor RAM primitive.

Test Plan:
- Reset with THR=2 -> clr_busy=1 for exactly 64 cycles then 0; every register of both banks reads 0.
- Write thr_mx=1, rd_mx=5, sel=1111, dat=0xDEADBEEF; read r5 in slot thr_if=1 -> opa_if=0xDEADBEEF; read r5 in slot 0 -> 0.
- Write sel=0100, dat=0x00AB0000 to r3 -> r3 reads 0x000000AB; sel=0110 -> r3 unchanged.
- Write to r0 with 0xFFFFFFFF -> r0 reads 0 on all three ports.
- Same-edge write/read of r7 in the same thread: with AEMB2_RF_BYPASS_EN -> new value next cycle; without -> old value.
- Drop grst to 0 at clear index 20, release -> clear restarts at index 0; clr_busy high for a full THR*32 cycles; writes issued during clear are lost.

Source files
------------

// File: rtl/aemb2_pkg.sv
// Shared constants and types for the AEMB2 multi-thread register file.
package aemb2_pkg;

  localparam int NREG = 32;
  localparam int DW   = 32;

  localparam logic [3:0] SEL_W  = 4'b1111;
  localparam logic [3:0] SEL_HH = 4'b1100;
  localparam logic [3:0] SEL_HL = 4'b0011;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B0 = 4'b0001;

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } clr_state_e;

endpackage

// File: rtl/aemb2_lane_ext.sv
// Writeback lane extraction: selects the addressed byte/half/word of the
// bus-positioned data and zero-extends it; vld_o is low for unsupported selects.
module aemb2_lane_ext
  import aemb2_pkg::*;
(
  input  logic [3:0]    sel_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] val_o
);

  always_comb begin
    vld_o = 1'b1;
    val_o = '0;
    case (sel_i)
      SEL_W:   val_o = dat_i;
      SEL_HH:  val_o = {16'h0000, dat_i[31:16]};
      SEL_HL:  val_o = {16'h0000, dat_i[15:0]};
      SEL_B3:  val_o = {24'h000000, dat_i[31:24]};
      SEL_B2:  val_o = {24'h000000, dat_i[23:16]};
      SEL_B1:  val_o = {24'h000000, dat_i[15:8]};
      SEL_B0:  val_o = {24'h000000, dat_i[7:0]};
      default: vld_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/aemb2_mtrf.sv
// Multi-thread GPR file: THR banks of 32x32, registered A/B/D read ports,
// round-robin thread slot and post-reset clear. Optional macro AEMB2_RF_BYPASS_EN.
module aemb2_mtrf
  import aemb2_pkg::*;
#(
  parameter int THR = 2,
  parameter int TW  = (THR > 1) ? $clog2(THR) : 1
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          dena,
  input  logic [4:0]    ra_if,
  input  logic [4:0]    rb_if,
  input  logic [4:0]    rd_if,
  input  logic          wre_mx,
  input  logic [TW-1:0] thr_mx,
  input  logic [4:0]    rd_mx,
  input  logic [3:0]    sel_mx,
  input  logic [31:0]   dat_mx,
  output logic [31:0]   opa_if,
  output logic [31:0]   opb_if,
  output logic [31:0]   opd_if,
  output logic [TW-1:0] thr_if,
  output logic          clr_busy
);

  // Storage is indexed by {thread, reg}; for THR=1 the upper half is never touched.
  localparam int             IW    = TW + 5;
  localparam int             DEPTH = 1 << IW;
  localparam logic [IW-1:0]  LAST  = IW'(THR * NREG - 1);

  clr_state_e      st_q, st_d;
  logic [IW-1:0]   clr_idx_q, clr_idx_d;
  logic            run;
  logic [TW-1:0]   thr_q, thr_d;
  logic [DW-1:0]   opa_q, opb_q, opd_q;
  logic [DW-1:0]   rda_d, rdb_d, rdd_d;
  logic [DW-1:0]   rf_q [DEPTH];

  logic            lane_vld;
  logic [DW-1:0]   lane_val;
  logic            wr_en, wr_go;
  logic [IW-1:0]   wr_idx;
  logic [DW-1:0]   wr_dat;

  // Clear sequencer: state register
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      st_q      <= ST_CLR;
      clr_idx_q <= '0;
    end else begin
      st_q      <= st_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Clear sequencer: next state
  always_comb begin
    st_d      = st_q;
    clr_idx_d = clr_idx_q;
    case (st_q)
      ST_CLR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST) begin
          st_d      = ST_RUN;
          clr_idx_d = '0;
        end
      end
      ST_RUN:  st_d = ST_RUN;
      default: st_d = ST_CLR;
    endcase
  end

  // Clear sequencer: outputs
  always_comb begin
    clr_busy = (st_q == ST_CLR);
    run      = (st_q == ST_RUN);
  end

  always_comb begin
    thr_d = thr_q;
    if (run && dena)
      thr_d = (THR == 1) ? '0 : thr_q + 1'b1;
  end

  aemb2_lane_ext u_lane (
    .sel_i (sel_mx),
    .dat_i (dat_mx),
    .vld_o (lane_vld),
    .val_o (lane_val)
  );

  // Single write port: the clear sequencer owns it until RUN.
  always_comb begin
    wr_en  = run && wre_mx && lane_vld && (rd_mx != 5'd0);
    wr_go  = clr_busy || wr_en;
    wr_idx = clr_busy ? clr_idx_q : {thr_mx, rd_mx};
    wr_dat = clr_busy ? '0 : lane_val;
  end

  always_ff @(posedge gclk) begin
    if (wr_go)
      rf_q[wr_idx] <= wr_dat;
  end

  // Reads target the slot thr_if moves to on this edge.
  always_comb begin
    rda_d = (ra_if == 5'd0) ? '0 : rf_q[{thr_d, ra_if}];
    rdb_d = (rb_if == 5'd0) ? '0 : rf_q[{thr_d, rb_if}];
    rdd_d = (rd_if == 5'd0) ? '0 : rf_q[{thr_d, rd_if}];
`ifdef AEMB2_RF_BYPASS_EN
    if (wr_en && (thr_mx == thr_d)) begin
      if (ra_if == rd_mx) rda_d = lane_val;
      if (rb_if == rd_mx) rdb_d = lane_val;
      if (rd_if == rd_mx) rdd_d = lane_val;
    end
`endif
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      thr_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      opd_q <= '0;
    end else begin
      thr_q <= thr_d;
      if (run && dena) begin
        opa_q <= rda_d;
        opb_q <= rdb_d;
        opd_q <= rdd_d;
      end
    end
  end

  assign opa_if = opa_q;
  assign opb_if = opb_q;
  assign opd_if = opd_q;
  assign thr_if = thr_q;

endmodule

// File: tb/tb_aemb2_mtrf.sv
// Directed self-checking bench for aemb2_mtrf with THR=2.
module tb_aemb2_mtrf;

  logic        gclk = 1'b0;
  logic        grst;
  logic        dena;
  logic [4:0]  ra_if, rb_if, rd_if, rd_mx;
  logic        wre_mx;
  logic [0:0]  thr_mx;
  logic [3:0]  sel_mx;
  logic [31:0] dat_mx;
  logic [31:0] opa_if, opb_if, opd_if;
  logic [0:0]  thr_if;
  logic        clr_busy;

  int nvec = 0;
  int nerr = 0;
  int exp_thr = 0;

  aemb2_mtrf #(.THR(2), .TW(1)) dut (
    .gclk     (gclk),
    .grst     (grst),
    .dena     (dena),
    .ra_if    (ra_if),
    .rb_if    (rb_if),
    .rd_if    (rd_if),
    .wre_mx   (wre_mx),
    .thr_mx   (thr_mx),
    .rd_mx    (rd_mx),
    .sel_mx   (sel_mx),
    .dat_mx   (dat_mx),
    .opa_if   (opa_if),
    .opb_if   (opb_if),
    .opd_if   (opd_if),
    .thr_if   (thr_if),
    .clr_busy (clr_busy)
  );

  always #5 gclk = ~gclk;

  task automatic tick();
    @(posedge gclk);
    @(negedge gclk);
  endtask

  task automatic idle_inputs();
    dena   = 1'b0;
    wre_mx = 1'b0;
    ra_if  = '0;
    rb_if  = '0;
    rd_if  = '0;
    thr_mx = '0;
    rd_mx  = '0;
    sel_mx = '0;
    dat_mx = '0;
  endtask

  task automatic do_write(input int t, input int r, input logic [3:0] s, input logic [31:0] d);
    thr_mx = 1'(t);
    rd_mx  = 5'(r);
    sel_mx = s;
    dat_mx = d;
    wre_mx = 1'b1;
    tick();
    wre_mx = 1'b0;
  endtask

  // Advance one slot if needed so the next dena edge lands on thread t.
  task automatic align(input int t);
    dena = 1'b1;
    if (((exp_thr + 1) % 2) != t) begin
      tick();
      exp_thr = (exp_thr + 1) % 2;
    end
  endtask

  task automatic read3(input int t, input int a, input int b, input int d);
    align(t);
    ra_if = 5'(a);
    rb_if = 5'(b);
    rd_if = 5'(d);
    tick();
    exp_thr = (exp_thr + 1) % 2;
    dena = 1'b0;
  endtask

  // Counts cycles of clr_busy after release, checking outputs stay 0 meanwhile.
  task automatic run_clear(output int cnt, output int bad);
    cnt = 0;
    bad = 0;
    dena  = 1'b1;
    ra_if = 5'd5;
    rb_if = 5'd7;
    rd_if = 5'd3;
    while (clr_busy === 1'b1 && cnt < 200) begin
      if ({opa_if, opb_if, opd_if} !== 96'h0 || thr_if !== 1'b0) bad++;
      tick();
      cnt++;
    end
    dena = 1'b0;
    exp_thr = 0;
  endtask

  task automatic test_reset();
    int cnt, bad;
    idle_inputs();
    grst = 1'b0;
    @(negedge gclk);
    @(negedge gclk);
    nvec++;
    if ({opa_if, opb_if, opd_if} !== 96'h0) begin
      nerr++; $display("FAIL reset_ops got %h want 0", {opa_if, opb_if, opd_if});
    end
    nvec++;
    if (thr_if !== 1'b0 || clr_busy !== 1'b1) begin
      nerr++; $display("FAIL reset_ctl got thr=%b busy=%b want thr=0 busy=1", thr_if, clr_busy);
    end
    grst = 1'b1;
    run_clear(cnt, bad);
    nvec++;
    if (cnt !== 64) begin
      nerr++; $display("FAIL clear_len got %0d want 64", cnt);
    end
    nvec++;
    if (bad !== 0) begin
      nerr++; $display("FAIL clear_hold got %0d nonzero cycles want 0", bad);
    end
    nvec++;
    if (thr_if !== 1'b0) begin
      nerr++; $display("FAIL run_thr0 got %b want 0", thr_if);
    end
    for (int r = 0; r < 32; r++) begin
      for (int t = 0; t < 2; t++) begin
        read3(t, r, r, r);
        nvec++;
        if ({opa_if, opb_if, opd_if} !== 96'h0 || thr_if !== 1'(t)) begin
          nerr++; $display("FAIL cleared_r%0d_t%0d got %h thr=%b want 0 thr=%0d",
                           r, t, {opa_if, opb_if, opd_if}, thr_if, t);
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_write(1, 5, 4'b1111, 32'hDEADBEEF);
    read3(1, 5, 5, 5);
    nvec++;
    if (opa_if !== 32'hDEADBEEF || opb_if !== 32'hDEADBEEF || opd_if !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL wr_t1_r5 got %h %h %h want deadbeef", opa_if, opb_if, opd_if);
    end
    nvec++;
    if (thr_if !== 1'b1) begin
      nerr++; $display("FAIL wr_slot got %b want 1", thr_if);
    end
    read3(0, 5, 5, 5);
    nvec++;
    if ({opa_if, opb_if, opd_if} !== 96'h0) begin
      nerr++; $display("FAIL wr_t0_r5 got %h want 0", {opa_if, opb_if, opd_if});
    end
  endtask

  task automatic test_hold();
    logic [31:0] prev;
    read3(1, 5, 0, 0);
    prev = opa_if;
    dena  = 1'b0;
    ra_if = 5'd3;
    tick();
    tick();
    nvec++;
    if (opa_if !== 32'hDEADBEEF || thr_if !== 1'b1 || opa_if !== prev) begin
      nerr++; $display("FAIL dena_hold got %h thr=%b want deadbeef thr=1", opa_if, thr_if);
    end
  endtask

  task automatic test_lanes();
    logic [3:0]  sel_t [12];
    logic [31:0] dat_t [12];
    logic [31:0] exp_t [12];
    sel_t[0]  = 4'b0100; dat_t[0]  = 32'h00AB0000; exp_t[0]  = 32'h000000AB;
    sel_t[1]  = 4'b0110; dat_t[1]  = 32'hFFFFFFFF; exp_t[1]  = 32'h000000AB;
    sel_t[2]  = 4'b1100; dat_t[2]  = 32'h12345678; exp_t[2]  = 32'h00001234;
    sel_t[3]  = 4'b0011; dat_t[3]  = 32'h12345678; exp_t[3]  = 32'h00005678;
    sel_t[4]  = 4'b1000; dat_t[4]  = 32'h12345678; exp_t[4]  = 32'h00000012;
    sel_t[5]  = 4'b0100; dat_t[5]  = 32'h12345678; exp_t[5]  = 32'h00000034;
    sel_t[6]  = 4'b0010; dat_t[6]  = 32'h12345678; exp_t[6]  = 32'h00000056;
    sel_t[7]  = 4'b0001; dat_t[7]  = 32'h12345678; exp_t[7]  = 32'h00000078;
    sel_t[8]  = 4'b1111; dat_t[8]  = 32'h12345678; exp_t[8]  = 32'h12345678;
    sel_t[9]  = 4'b0000; dat_t[9]  = 32'hAAAAAAAA; exp_t[9]  = 32'h12345678;
    sel_t[10] = 4'b1010; dat_t[10] = 32'hAAAAAAAA; exp_t[10] = 32'h12345678;
    sel_t[11] = 4'b0111; dat_t[11] = 32'hAAAAAAAA; exp_t[11] = 32'h12345678;
    for (int i = 0; i < 12; i++) begin
      do_write(0, 3, sel_t[i], dat_t[i]);
      read3(0, 3, 3, 3);
      nvec++;
      if (opa_if !== exp_t[i] || opb_if !== exp_t[i] || opd_if !== exp_t[i]) begin
        nerr++; $display("FAIL lane_%0d sel=%b got %h want %h", i, sel_t[i], opa_if, exp_t[i]);
      end
    end
  endtask

  task automatic test_r0();
    do_write(0, 0, 4'b1111, 32'hFFFFFFFF);
    do_write(1, 0, 4'b1111, 32'hFFFFFFFF);
    for (int t = 0; t < 2; t++) begin
      read3(t, 0, 0, 0);
      nvec++;
      if ({opa_if, opb_if, opd_if} !== 96'h0) begin
        nerr++; $display("FAIL r0_t%0d got %h want 0", t, {opa_if, opb_if, opd_if});
      end
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] exp_new;
    do_write(0, 7, 4'b1111, 32'h11111111);
    align(0);
    ra_if  = 5'd7;
    rb_if  = 5'd7;
    rd_if  = 5'd5;
    thr_mx = 1'b0;
    rd_mx  = 5'd7;
    sel_mx = 4'b1111;
    dat_mx = 32'h22222222;
    wre_mx = 1'b1;
    tick();
    exp_thr = (exp_thr + 1) % 2;
    wre_mx = 1'b0;
    dena   = 1'b0;
`ifdef AEMB2_RF_BYPASS_EN
    exp_new = 32'h22222222;
`else
    exp_new = 32'h11111111;
`endif
    nvec++;
    if (opa_if !== exp_new || opb_if !== exp_new || opd_if !== 32'h0) begin
      nerr++; $display("FAIL same_edge got %h %h %h want %h %h 0", opa_if, opb_if, opd_if, exp_new, exp_new);
    end
    read3(0, 7, 7, 7);
    nvec++;
    if (opa_if !== 32'h22222222) begin
      nerr++; $display("FAIL same_edge_after got %h want 22222222", opa_if);
    end
    // Same-edge write to thread 0 while the read slot is thread 1: never forwarded.
    align(1);
    ra_if  = 5'd7;
    rb_if  = 5'd5;
    rd_if  = 5'd7;
    thr_mx = 1'b0;
    rd_mx  = 5'd7;
    sel_mx = 4'b1111;
    dat_mx = 32'h33333333;
    wre_mx = 1'b1;
    tick();
    exp_thr = (exp_thr + 1) % 2;
    wre_mx = 1'b0;
    dena   = 1'b0;
    nvec++;
    if (opa_if !== 32'h0 || opb_if !== 32'hDEADBEEF || opd_if !== 32'h0) begin
      nerr++; $display("FAIL other_thr got %h %h %h want 0 deadbeef 0", opa_if, opb_if, opd_if);
    end
  endtask

  task automatic test_restart();
    int cnt, bad;
    @(negedge gclk);
    grst = 1'b0;
    #1;
    grst = 1'b1;
    @(negedge gclk);
    thr_mx = 1'b0;
    rd_mx  = 5'd2;
    sel_mx = 4'b1111;
    dat_mx = 32'hCAFEF00D;
    wre_mx = 1'b1;
    dena   = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    grst = 1'b0;
    #1;
    nvec++;
    if (clr_busy !== 1'b1 || {opa_if, opb_if, opd_if} !== 96'h0) begin
      nerr++; $display("FAIL midclear_rst got busy=%b ops=%h want 1 0", clr_busy, {opa_if, opb_if, opd_if});
    end
    @(negedge gclk);
    grst = 1'b1;
    run_clear(cnt, bad);
    wre_mx = 1'b0;
    nvec++;
    if (cnt !== 64) begin
      nerr++; $display("FAIL restart_len got %0d want 64", cnt);
    end
    nvec++;
    if (bad !== 0) begin
      nerr++; $display("FAIL restart_hold got %0d nonzero cycles want 0", bad);
    end
    read3(1, 5, 5, 5);
    nvec++;
    if ({opa_if, opb_if, opd_if} !== 96'h0) begin
      nerr++; $display("FAIL restart_t1_r5 got %h want 0", {opa_if, opb_if, opd_if});
    end
    read3(0, 2, 7, 3);
    nvec++;
    if ({opa_if, opb_if, opd_if} !== 96'h0) begin
      nerr++; $display("FAIL clear_wr_lost got %h want 0", {opa_if, opb_if, opd_if});
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_lanes();
    test_r0();
    test_same_edge();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
